serial_subtractor: RTL and testbench

Bit-serial ripple-borrow subtractor computing D = A − B over WIDTH bits. It uses one full-subtractor cell and processes one bit per clock, LSB first, with a start/done handshake. It is the subtract counterpart of the team's parallel ripple-carry adder and sits in the CA_2 datapath, where area matters more than latency. Operands are latched on start, so the upstream logic may change them immediately afterwards.

---
 rtl/serial_subtractor.sv | 118 +++++++++++
 tb/tb_serial_subtractor.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial ripple-borrow subtractor: D = A - B, one full-subtractor cell, LSB first.
// Operands are captured on an accepted start; results are registered and held until the next done.
module serial_subtractor #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] D,
  output logic             Bout,
  output logic             Z
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] d_sr_q, d_sr_d;
  logic             br_q, br_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic             bout_q, bout_d;
  logic             z_q, z_d;

  logic             a_bit, b_bit, diff_bit, br_nxt;
  logic [WIDTH-1:0] d_shift;

  // Full-subtractor cell shared by every bit position.
  assign a_bit    = a_sr_q[0];
  assign b_bit    = b_sr_q[0];
  assign diff_bit = a_bit ^ b_bit ^ br_q;
  assign br_nxt   = (~a_bit & b_bit) | (~a_bit & br_q) | (b_bit & br_q);
  assign d_shift  = {diff_bit, d_sr_q[WIDTH-1:1]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_sr_d  = a_sr_q;
    b_sr_d  = b_sr_q;
    d_sr_d  = d_sr_q;
    br_d    = br_q;
    done_d  = 1'b0;
    d_d     = d_q;
    bout_d  = bout_q;
    z_d     = z_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_sr_d  = A;
          b_sr_d  = B;
          d_sr_d  = '0;
          br_d    = 1'b0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_sr_d = a_sr_q >> 1;
        b_sr_d = b_sr_q >> 1;
        d_sr_d = d_shift;
        br_d   = br_nxt;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == LAST_BIT) begin
          // Publish only the completed word; outputs never show a partial result.
          d_d     = d_shift;
          bout_d  = br_nxt;
          z_d     = (d_shift == '0);
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      d_sr_q  <= '0;
      br_q    <= 1'b0;
      done_q  <= 1'b0;
      d_q     <= '0;
      bout_q  <= 1'b0;
      z_q     <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      d_sr_q  <= d_sr_d;
      br_q    <= br_d;
      done_q  <= done_d;
      d_q     <= d_d;
      bout_q  <= bout_d;
      z_q     <= z_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = done_q;
  assign D    = d_q;
  assign Bout = bout_q;
  assign Z    = z_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed-vector bench for serial_subtractor at WIDTH=3 with hand-computed expectations.
module tb_serial_subtractor;

  localparam int WIDTH = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] A, B;
  logic             busy, done, Bout, Z;
  logic [WIDTH-1:0] D;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .start(start), .A(A), .B(B),
    .busy(busy), .done(done), .D(D), .Bout(Bout), .Z(Z)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Advance until done is seen (bounded); lat = edges after accept, bcnt = extra busy cycles seen.
  task automatic wait_done(output int lat, output int bcnt);
    lat  = 0;
    bcnt = 0;
    while (lat < 12) begin
      tick();
      lat++;
      if (done) break;
      if (busy) bcnt++;
    end
  endtask

  task automatic run_op(input string tag, input logic [2:0] a, input logic [2:0] b,
                        input logic [2:0] ed, input logic eb, input logic ez);
    int lat, bcnt;
    A = a; B = b; start = 1'b1;
    tick();
    start = 1'b0;
    A = ~a; B = ~b;
    check({tag, ".busy_on"}, busy, 1);
    wait_done(lat, bcnt);
    check({tag, ".latency"}, lat, WIDTH);
    check({tag, ".busy_cycles"}, bcnt + 1, WIDTH);
    check({tag, ".busy_at_done"}, busy, 0);
    check({tag, ".D"}, D, ed);
    check({tag, ".Bout"}, Bout, eb);
    check({tag, ".Z"}, Z, ez);
    tick();
    check({tag, ".done_single"}, done, 0);
    check({tag, ".D_hold"}, D, ed);
  endtask

  initial begin
    int lat, bcnt, ndone, last_done;
    rst = 1'b1; start = 1'b0; A = '0; B = '0;
    #2;
    check("rst.busy", busy, 0);
    check("rst.done", done, 0);
    check("rst.D", D, 0);
    check("rst.Bout", Bout, 0);
    check("rst.Z", Z, 1);
    tick(); tick();
    rst = 1'b0;
    tick();

    run_op("basic", 3'd5, 3'd3, 3'd2, 1'b0, 1'b0);
    run_op("under", 3'd3, 3'd5, 3'd6, 1'b1, 1'b0);
    run_op("under0", 3'd0, 3'd7, 3'd1, 1'b1, 1'b0);
    run_op("zero77", 3'd7, 3'd7, 3'd0, 1'b0, 1'b1);
    run_op("zero00", 3'd0, 3'd0, 3'd0, 1'b0, 1'b1);

    // Start and new operands while busy must be ignored.
    A = 3'd6; B = 3'd1; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    A = 3'd2; B = 3'd3; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(lat, bcnt);
    check("busy_ign.latency", lat + 2, WIDTH);
    check("busy_ign.D", D, 5);
    check("busy_ign.Bout", Bout, 0);
    check("busy_ign.Z", Z, 0);
    ndone = 0;
    repeat (6) begin
      tick();
      if (done) ndone++;
    end
    check("busy_ign.no_second_done", ndone, 0);
    check("busy_ign.idle", busy, 0);

    // Asynchronous reset in the middle of an operation.
    A = 3'd4; B = 3'd1; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    #2;
    rst = 1'b1;
    #1;
    check("midrst.busy", busy, 0);
    check("midrst.D", D, 0);
    check("midrst.Bout", Bout, 0);
    check("midrst.Z", Z, 1);
    ndone = 0;
    repeat (3) begin
      tick();
      if (done) ndone++;
    end
    rst = 1'b0;
    repeat (4) begin
      tick();
      if (done) ndone++;
    end
    check("midrst.no_done", ndone, 0);
    run_op("after_rst", 3'd4, 3'd1, 3'd3, 1'b0, 1'b0);

    // Back-to-back sweep with start held high; operands change right after each accept.
    A = 3'd0; B = 3'd0; start = 1'b1;
    tick();
    last_done = 0;
    for (int i = 0; i < 64; i++) begin
      int a, b, ed;
      a  = i >> 3;
      b  = i & 7;
      ed = (a - b) & 7;
      if (i < 63) begin
        A = 3'((i + 1) >> 3);
        B = 3'((i + 1) & 7);
      end else begin
        start = 1'b0;
      end
      wait_done(lat, bcnt);
      check($sformatf("sweep%0d.D", i), D, ed);
      check($sformatf("sweep%0d.Bout", i), Bout, (a < b) ? 1 : 0);
      check($sformatf("sweep%0d.Z", i), Z, (ed == 0) ? 1 : 0);
      if (i > 0) check($sformatf("sweep%0d.period", i), cyc - last_done, WIDTH + 1);
      last_done = cyc;
      tick();
    end
    check("sweep.end_done", done, 0);
    check("sweep.end_busy", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
